// File: rtl/cp0_defs.sv
// CP0 shared definitions: register indices, exception codes
// and bit-field positions for SR and Cause.
package cp0_defs;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;
    localparam int SR_EXL    = 1;
    localparam int SR_IE     = 0;
    localparam int CA_BD     = 31;
    localparam int CA_IP_LO  = 10;
    localparam int CA_IP_HI  = 15;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;

endpackage

// File: rtl/cp0_trap_arbiter.sv
// Decides whether to trap this cycle and which ExcCode to record.
// Interrupts win over synchronous exceptions.
module cp0_trap_arbiter
    import cp0_defs::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] exc_rec
);

    always_comb begin
        int_req = (|(hw_int & im)) & ie & ~exl;
        exc_req = (exc_code != 5'd0) & ~exl;
        req     = int_req | exc_req;
        exc_rec = int_req ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, trap request
// generation and eret handling for the M stage.
module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID = 32'h2020_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_rec;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    cp0_trap_arbiter u_arb (
        .hw_int   (hw_int),
        .im       (sr_im),
        .ie       (sr_ie),
        .exl      (sr_exl),
        .exc_code (exc_code),
        .int_req  (int_req),
        .exc_req  (exc_req),
        .req      (req),
        .exc_rec  (exc_rec)
    );

    always_comb begin
        sr_val = 32'd0;
        sr_val[SR_IM_HI:SR_IM_LO] = sr_im;
        sr_val[SR_EXL] = sr_exl;
        sr_val[SR_IE]  = sr_ie;
        cause_val = 32'd0;
        cause_val[CA_BD] = cause_bd;
        cause_val[CA_IP_HI:CA_IP_LO] = cause_ip;
        cause_val[CA_EXC_HI:CA_EXC_LO] = cause_exc;
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            REG_SR:    dout = sr_val;
            REG_CAUSE: dout = cause_val;
            REG_EPC:   dout = epc;
            REG_PRID:  dout = PRID;
            default:   dout = 32'd0;
        endcase
    end

    assign epc_out = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd;
                cause_exc <= exc_rec;
                epc       <= bd ? pc - 32'd4 : pc;
            end else begin
                if (we && addr == REG_SR) begin
                    sr_im  <= din[SR_IM_HI:SR_IM_LO];
                    sr_exl <= din[SR_EXL];
                    sr_ie  <= din[SR_IE];
                end
                if (we && addr == REG_EPC)
                    epc <= din;
                // eret wins over a same-cycle SR write to EXL
                if (eret)
                    sr_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
// Inputs change 1ns after the rising edge; outputs checked before the next.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic        eret;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;

    int checks   = 0;
    int failures = 0;

    cp0_unit dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we       (we),
        .din      (din),
        .dout     (dout),
        .pc       (pc),
        .bd       (bd),
        .exc_code (exc_code),
        .eret     (eret),
        .hw_int   (hw_int),
        .req      (req),
        .epc_out  (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 5'd0; we = 1'b0; din = 32'd0;
        pc = 32'd0; bd = 1'b0; exc_code = 5'd0; eret = 1'b0;
        hw_int = 6'd0;
        tick();
        tick();
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h2020_0007);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_epc_out", epc_out, 32'h0);
        reset = 1'b0;
        tick();

        // timer interrupt, zero latency
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        pc = 32'h0000_1000;
        hw_int = 6'b000001;
        #1;
        chk("int_req", {31'd0, req}, 32'd1);
        tick();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_1000);
        rd("int_sr", 5'd12, 32'h0000_0403);
        chk("int_req_drop", {31'd0, req}, 32'd0);

        // eret with interrupt pending re-traps next cycle
        eret = 1'b1;
        #1;
        chk("eret_no_req", {31'd0, req}, 32'd0);
        tick();
        eret = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("eret_retrap", {31'd0, req}, 32'd1);
        pc = 32'h0000_2000;
        tick();
        chk("retrap_epc", epc_out, 32'h0000_2000);

        // overflow in delay slot with IE=0
        hw_int = 6'd0;
        mtc0(5'd12, 32'h0);
        rd("sr_clear", 5'd12, 32'h0);
        exc_code = 5'd12; pc = 32'h0000_3010; bd = 1'b1;
        #1;
        chk("ov_req", {31'd0, req}, 32'd1);
        tick();
        exc_code = 5'd0; bd = 1'b0;
        rd("ov_cause", 5'd13, 32'h8000_0030);
        rd("ov_epc", 5'd14, 32'h0000_300C);
        rd("ov_sr", 5'd12, 32'h0000_0002);

        // interrupt beats exception
        mtc0(5'd12, 32'h0000_0801);
        hw_int = 6'b000010; exc_code = 5'd10; pc = 32'h0000_4000;
        #1;
        chk("pri_req", {31'd0, req}, 32'd1);
        tick();
        exc_code = 5'd0; hw_int = 6'd0;
        rd("pri_cause", 5'd13, 32'h0000_0800);
        rd("pri_epc", 5'd14, 32'h0000_4000);

        // Cause is not writable; IP follows hw_int
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd("eret2_sr", 5'd12, 32'h0000_0801);
        hw_int = 6'b000100;
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_1000);

        // mtc0 EPC dropped under a same-cycle trap
        hw_int = 6'd0;
        exc_code = 5'd4; pc = 32'h0000_5000;
        addr = 5'd14; din = 32'hDEAD_BEEF; we = 1'b1;
        #1;
        chk("drop_req", {31'd0, req}, 32'd1);
        tick();
        we = 1'b0; exc_code = 5'd0;
        chk("drop_epc", epc_out, 32'h0000_5000);
        rd("drop_cause", 5'd13, 32'h0000_0010);

        // EPC wraparound at pc=0 in delay slot
        eret = 1'b1;
        tick();
        eret = 1'b0;
        exc_code = 5'd5; pc = 32'h0; bd = 1'b1;
        tick();
        exc_code = 5'd0; bd = 1'b0;
        chk("wrap_epc", epc_out, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0014);

        // mtc0 SR with EXL=1 masks traps
        eret = 1'b1;
        tick();
        eret = 1'b0;
        mtc0(5'd12, 32'h0000_0403);
        hw_int = 6'b000001; exc_code = 5'd10;
        #1;
        chk("exl_mask", {31'd0, req}, 32'd0);
        exc_code = 5'd0;

        // reset while EXL=1 with interrupt pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("rst2_sr", 5'd12, 32'h0);
        chk("rst2_epc", epc_out, 32'h0);
        chk("rst2_req", {31'd0, req}, 32'd0);
        tick();
        rd("rst2_ip", 5'd13, 32'h0000_0400);
        chk("rst2_req_hold", {31'd0, req}, 32'd0);
        rd("other_addr", 5'd16, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
